// File: rtl/seq_divider_if.sv
// seq_divider_if -- request/response bundle for the sequential divider.
//   A, B      : signed dividend / divisor (sampled only at the accept edge)
//   start     : request a division (honoured only while the divider is idle)
//   busy      : operation in progress
//   done      : one-cycle completion pulse
//   div_zero  : divisor was zero (meaningful only while done is high)
//   result    : {remainder[31:0], quotient[31:0]}
interface seq_divider_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [63:0] result;

  modport master (output A, B, start, input busy, done, div_zero, result);
  modport slave  (input A, B, start, output busy, done, div_zero, result);
endinterface

// File: rtl/seq_divider.sv
// seq_divider -- 32-bit signed non-restoring divider, one quotient bit per clock.
//   clock : rising-edge clock
//   clear : asynchronous active-high reset
//   bus   : seq_divider_if slave port (A, B, start in; busy, done, div_zero, result out)
// Latency is 33 cycles from the accept edge to the done cycle (1 cycle for a zero divisor).
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | 32 non-restoring iterations (or one pass for a zero divisor)
//   SIGN  | remainder restore, sign fix-up, write result
//   DONE  | done pulse, back to IDLE next edge
module seq_divider (
  input  logic         clock,
  input  logic         clear,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state, state_nxt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic        a_neg, q_neg, dz;

  logic        busy_d, done_d, div_zero_d;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, rem_it;
  logic [31:0] quo_it, rem_fix, q_final, r_final, a_orig;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = CALC;
      CALC: begin
        if (dz)             state_nxt = DONE;
        else if (cnt == '0) state_nxt = SIGN;
      end
      SIGN: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition.
  always_comb begin
    busy_d     = (state_nxt != IDLE);
    done_d     = (state_nxt == DONE);
    div_zero_d = (state == CALC) && dz;
  end

  always_comb begin
    abs_a   = bus.A[31] ? -bus.A : bus.A;
    abs_b   = bus.B[31] ? -bus.B : bus.B;
    // Non-restoring step: the sign of the previous partial remainder picks add or subtract.
    // The 33-bit wrap during the shift is harmless because the post-step value fits.
    shifted = {rem[31:0], quo[31]};
    rem_it  = rem[32] ? shifted + {1'b0, dvs} : shifted - {1'b0, dvs};
    quo_it  = {quo[30:0], ~rem_it[32]};
    rem_fix = rem[32] ? rem[31:0] + dvs : rem[31:0];
    q_final = q_neg ? -quo : quo;
    r_final = a_neg ? -rem_fix : rem_fix;
    // Before any iteration quo still holds |A|; re-apply the sign to recover A.
    a_orig  = a_neg ? -quo : quo;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.result   <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      a_neg        <= 1'b0;
      q_neg        <= 1'b0;
      dz           <= 1'b0;
    end else begin
      bus.busy     <= busy_d;
      bus.done     <= done_d;
      bus.div_zero <= div_zero_d;
      case (state)
        IDLE: if (bus.start) begin
          rem   <= '0;
          quo   <= abs_a;
          dvs   <= abs_b;
          a_neg <= bus.A[31];
          q_neg <= bus.A[31] ^ bus.B[31];
          dz    <= (bus.B == '0);
          cnt   <= 5'd31;
        end
        CALC: begin
          if (dz) begin
            bus.result <= {a_orig, 32'hFFFF_FFFF};
          end else begin
            rem <= rem_it;
            quo <= quo_it;
            if (cnt != '0) cnt <= cnt - 5'd1;
          end
        end
        SIGN: bus.result <= {r_final, q_final};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- scoreboard bench for seq_divider: expectations are queued at
// each accepted start and compared when done pulses.
module tb_seq_divider;

  logic clock = 1'b0;
  logic clear;
  int   cyc = 0;

  seq_divider_if bus ();

  seq_divider dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t   e;
    longint q, r;
    e.acc = 0;
    if (b == 0) begin
      e.res = {a, 32'hFFFF_FFFF};
      e.dz  = 1'b1;
    end else begin
      q     = longint'(a) / longint'(b);
      r     = longint'(a) % longint'(b);
      e.res = {r[31:0], q[31:0]};
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (!clear && bus.done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", bus.result, e.res);
        check("div_zero", 64'(bus.div_zero), 64'(e.dz));
        check("latency", 64'(cyc - e.acc), e.dz ? 64'd1 : 64'd33);
        check("busy_at_done", 64'(bus.busy), 64'd1);
      end
    end
  end

  task automatic do_div(input int a, input int b);
    int   t = 0;
    exp_t e;
    @(negedge clock);
    while (bus.busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) check("idle_timeout", 64'd1, 64'd0);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    e     = model(a, b);
    e.acc = cyc;
    sbq.push_back(e);
    check("accept_busy", 64'(bus.busy), 64'd1);
    @(negedge clock);
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (sbq.size() != 0) check("drain_timeout", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_result"}, bus.result, 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_div_zero"}, 64'(bus.div_zero), 64'd0);
  endtask

  initial begin
    int sp[5];
    int a, b, t;
    sp = '{32'h8000_0000, 32'h7FFF_FFFF, -1, 1, 0};

    clear     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    clear = 1'b0;

    do_div(100, 7);
    drain();
    do_div(-100, 7);
    do_div(100, -7);
    do_div(32'h8000_0000, -1);
    do_div(5, 0);
    do_div(-5, 0);
    do_div(7, 100);
    do_div(32'h7FFF_FFFF, 1);
    drain();

    // start while busy must neither queue nor restart
    do_div(100, 7);
    repeat (3) @(negedge clock);
    bus.A     = 1;
    bus.B     = 1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_ignored_start", 64'(bus.busy), 64'd1);
    drain();

    // start during the done cycle lands on the DONE->IDLE edge and is not taken
    do_div(20, 3);
    t = 0;
    while (!bus.done && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
    bus.A     = 9;
    bus.B     = 3;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    check("no_accept_from_done", 64'(bus.busy), 64'd0);
    @(negedge clock);
    bus.start = 1'b0;
    drain();

    // clear mid-operation abandons the division
    bus.A     = 100;
    bus.B     = 7;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    #2;
    clear = 1'b1;
    #1;
    check_zero_outputs("clear_mid");
    @(negedge clock);
    clear = 1'b0;
    repeat (40) @(negedge clock);
    check_zero_outputs("after_clear");
    do_div(9, 3);
    drain();

    for (int i = 0; i < 1000; i++) begin
      a = (($urandom_range(7) == 0) ? sp[$urandom_range(4)] : int'($urandom));
      b = (($urandom_range(7) == 0) ? sp[$urandom_range(4)] : int'($urandom));
      if ($urandom_range(3) == 0) b = b >>> $urandom_range(30);
      if (b == 0) b = 1;
      do_div(a, b);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: clear  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: A  input  32  signed dividend, two's complement.
REQ-004 SHALL have port: B  input  32  signed divisor, two's complement.
REQ-005 SHALL have port: start  input  1  request to begin a division, sampled on the rising edge of clock.
REQ-006 SHALL have port: busy  output  1  high from the edge that accepts start until the edge that returns to IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: div_zero  output  1  high with done when the divisor was zero.
REQ-009 SHALL have port: result  output  64  {remainder[31:0], quotient[31:0]}, HI:LO layout matching the multiplier product.

Function
REQ-010 SHALL implement states IDLE, CALC, SIGN and DONE; all outputs SHALL be registered.
REQ-011 SHALL accept start only in IDLE; at accept edge k it SHALL latch |A| and |B| as 32-bit unsigned magnitudes, latch the sign of A and sign(A)^sign(B), load the iteration counter with 31, and enter CALC.
REQ-012 SHALL ignore changes on A and B after the accept edge.
REQ-013 SHALL ignore start while busy; the ignored start SHALL cause no queuing and no restart.
REQ-014 In CALC, SHALL perform one non-restoring iteration per edge (33-bit partial remainder, shift in one dividend bit, add or subtract the divisor magnitude by sign) for exactly 32 edges, k+1..k+32, then enter SIGN.
REQ-015 In SIGN at edge k+33, SHALL apply the final remainder restore if negative; negate the quotient if the quotient sign is 1; negate the remainder if the dividend was negative; write result; pulse done; enter DONE.
REQ-016 SHALL therefore assert done exactly during the cycle between edges k+33 and k+34, a latency of 33 cycles; DONE SHALL return to IDLE at edge k+34.
REQ-017 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend; A = quotient*B + remainder SHALL hold for all B != 0.
REQ-018 SHALL produce quotient 32'h80000000 and remainder 0 for 32'h80000000 / 32'hFFFFFFFF (natural wrap), with no overflow flag.
REQ-019 If B == 0 at accept, SHALL skip CALC and SIGN: at edge k+1 write quotient 32'hFFFFFFFF, write remainder A, set div_zero and done, and enter DONE.
REQ-020 div_zero SHALL be low at every completion with a non-zero divisor and SHALL be valid only while done is high.
REQ-021 result SHALL hold its last written value until the next completion or reset; it SHALL not change during CALC.
REQ-022 A start asserted in the same cycle that DONE returns to IDLE SHALL not be accepted; the earliest accept is the first edge with the state in IDLE.

Reset
REQ-023 While clear is high, SHALL force state to IDLE, result to 0, done to 0, busy to 0, div_zero to 0, and the counter to 0, independent of clock.
REQ-024 Reset asserted mid-CALC SHALL abandon the operation with no done pulse; after clear deasserts, the next start SHALL behave per REQ-011.

Verification
REQ-025 A=100, B=7, start at edge k -> done high only in cycle k+33, result = {32'd2, 32'd14}, div_zero=0.
REQ-026 A=-100, B=7 -> result = {32'hFFFFFFFE, 32'hFFFFFFF2}; A=100, B=-7 -> result = {32'd2, 32'hFFFFFFF2}.
REQ-027 A=32'h80000000, B=32'hFFFFFFFF -> result = {32'h0, 32'h80000000}, div_zero=0.
REQ-028 A=5, B=0 -> done and div_zero high in cycle k+1, result = {32'd5, 32'hFFFFFFFF}, busy low after edge k+2.
REQ-029 Start A=100, B=7; pulse start with A=1, B=1 at cycle k+5 -> the second start is ignored, result = {2, 14} at k+33; clear pulsed at cycle k+10 of a fresh operation -> no done, all outputs 0, and a following start A=9, B=3 -> {0, 3}.
REQ-030 Randomized 10^5 signed pairs with B != 0 -> result SHALL match a truncating reference model, and done SHALL occur exactly 33 cycles after each accept.
